// File: rtl/regfile_serial_rx_if.sv
// rtl/regfile_serial_rx_if.sv - stream, snapshot read and status signals of the register-file dump receiver
// REGFILE_SERIAL_RX_CHG_EN adds chg_mask to the bundle.
interface regfile_serial_rx_if #(
  parameter int NUM_REGS  = 16,
  parameter int REG_WIDTH = 8
);
  localparam int AW = $clog2(NUM_REGS);

  logic                 serial_in;
  logic                 start_in;
  logic [AW-1:0]        rd_addr;
  logic [REG_WIDTH-1:0] rd_data;
  logic                 frame_done;
  logic                 busy;
  logic [7:0]           frame_cnt;
  logic                 err_restart;
  logic                 err_clr;
`ifdef REGFILE_SERIAL_RX_CHG_EN
  logic [NUM_REGS-1:0]  chg_mask;

  modport slave (
    input  serial_in, start_in, rd_addr, err_clr,
    output rd_data, frame_done, busy, frame_cnt, err_restart, chg_mask
  );
  modport master (
    output serial_in, start_in, rd_addr, err_clr,
    input  rd_data, frame_done, busy, frame_cnt, err_restart, chg_mask
  );
`else
  modport slave (
    input  serial_in, start_in, rd_addr, err_clr,
    output rd_data, frame_done, busy, frame_cnt, err_restart
  );
  modport master (
    output serial_in, start_in, rd_addr, err_clr,
    input  rd_data, frame_done, busy, frame_cnt, err_restart
  );
`endif
endinterface

// File: rtl/regfile_serial_rx.sv
// rtl/regfile_serial_rx.sv - deserializes the register-file dump stream into a committed snapshot array
// REGFILE_SERIAL_RX_CHG_EN adds a per-word change mask updated on each commit.
module regfile_serial_rx #(
  parameter int NUM_REGS  = 16,
  parameter int REG_WIDTH = 8
) (
  input logic               clk,
  input logic               rst,
  regfile_serial_rx_if.slave bus
);
  localparam int AW = $clog2(NUM_REGS);
  localparam int BW = (REG_WIDTH > 1) ? $clog2(REG_WIDTH) : 1;
  localparam logic [AW-1:0] LAST_WORD = AW'(NUM_REGS - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(REG_WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                              state;
  logic [AW-1:0]                       word_idx;
  logic [BW-1:0]                       bit_idx;
  logic [NUM_REGS-1:0][REG_WIDTH-1:0]  shadow;
  logic [NUM_REGS-1:0][REG_WIDTH-1:0]  snapshot;
  logic [NUM_REGS-1:0][REG_WIDTH-1:0]  shadow_next;
  logic                                last_bit;
  logic                                busy_r;
  logic                                frame_done_r;
  logic                                err_r;
  logic [7:0]                          cnt_r;
  logic [31:0]                         addr_ext;

  // Shadow with the current bit merged in, so the commit copy includes it.
  always_comb begin
    shadow_next = shadow;
    shadow_next[word_idx][bit_idx] = bus.serial_in;
  end

  assign last_bit = (word_idx == LAST_WORD) && (bit_idx == LAST_BIT);

`ifdef REGFILE_SERIAL_RX_CHG_EN
  logic [NUM_REGS-1:0] chg_r;
  logic [NUM_REGS-1:0] chg_next;

  always_comb begin
    chg_next = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      chg_next[i] = (shadow_next[i] != snapshot[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chg_r <= '0;
    end else if (state == SHIFT && !bus.start_in && last_bit) begin
      chg_r <= chg_next;
    end
  end

  assign bus.chg_mask = chg_r;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      word_idx     <= '0;
      bit_idx      <= '0;
      shadow       <= '0;
      snapshot     <= '0;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
      err_r        <= 1'b0;
      cnt_r        <= 8'd0;
    end else begin
      frame_done_r <= 1'b0;
      if (bus.err_clr) begin
        err_r <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (bus.start_in) begin
            state    <= SHIFT;
            word_idx <= '0;
            bit_idx  <= '0;
            busy_r   <= 1'b1;
          end
        end
        SHIFT: begin
          // A restart discards the partial frame; the error set wins over err_clr.
          if (bus.start_in) begin
            err_r    <= 1'b1;
            word_idx <= '0;
            bit_idx  <= '0;
          end else begin
            shadow <= shadow_next;
            if (last_bit) begin
              snapshot     <= shadow_next;
              frame_done_r <= 1'b1;
              cnt_r        <= cnt_r + 8'd1;
              word_idx     <= '0;
              bit_idx      <= '0;
              busy_r       <= 1'b0;
              state        <= IDLE;
            end else if (bit_idx == LAST_BIT) begin
              bit_idx  <= '0;
              word_idx <= word_idx + 1'b1;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign addr_ext        = 32'(bus.rd_addr);
  assign bus.rd_data     = (addr_ext < NUM_REGS) ? snapshot[bus.rd_addr] : '0;
  assign bus.frame_done  = frame_done_r;
  assign bus.busy        = busy_r;
  assign bus.frame_cnt   = cnt_r;
  assign bus.err_restart = err_r;
endmodule

// File: tb/tb_regfile_serial_rx.sv
// tb/tb_regfile_serial_rx.sv - scoreboard bench for regfile_serial_rx (REGFILE_SERIAL_RX_CHG_EN optional)
module tb_regfile_serial_rx;
  localparam int NR = 16;
  localparam int RW = 8;
  localparam int FW = NR * RW;

  typedef struct {
    logic [FW-1:0] frame;
    logic [7:0]    cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   pulses = 0;
  int   exp_cnt = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  regfile_serial_rx_if #(.NUM_REGS(NR), .REG_WIDTH(RW)) bus ();

  regfile_serial_rx #(.NUM_REGS(NR), .REG_WIDTH(RW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always @(negedge clk) begin
    if (!rst && bus.frame_done) pulses++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FW-1:0] fill(input logic [RW-1:0] w);
    logic [FW-1:0] f;
    for (int i = 0; i < NR; i++) f[i*RW +: RW] = w;
    return f;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.start_in = 1'b0;
    bus.serial_in = 1'b0;
    bus.err_clr = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0;
    exp_q.delete();
  endtask

  task automatic start_pulse();
    @(negedge clk);
    bus.start_in = 1'b1;
    bus.serial_in = 1'b0;
  endtask

  task automatic send_bits(input logic [FW-1:0] f, input int lo, input int hi);
    for (int b = lo; b <= hi; b++) begin
      @(negedge clk);
      bus.start_in = 1'b0;
      bus.err_clr = 1'b0;
      bus.serial_in = f[b];
    end
  endtask

  task automatic push(input logic [FW-1:0] f);
    exp_t e;
    exp_cnt = (exp_cnt + 1) % 256;
    e.frame = f;
    e.cnt = 8'(exp_cnt);
    exp_q.push_back(e);
  endtask

  task automatic send_frame(input logic [FW-1:0] f, input bit record);
    start_pulse();
    send_bits(f, 0, FW - 1);
    if (record) push(f);
  endtask

  task automatic sweep(input string tag, input logic [FW-1:0] f);
    for (int i = 0; i < NR; i++) begin
      bus.rd_addr = 4'(i);
      #1;
      check($sformatf("%s_w%0d", tag, i), 32'(bus.rd_data), 32'(f[i*RW +: RW]));
    end
  endtask

  task automatic wait_commit(input string tag);
    exp_t e;
    bit   seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      seen = bus.frame_done;
    end
    check({tag, "_done"}, 32'(seen), 32'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check({tag, "_cnt"}, 32'(bus.frame_cnt), 32'(e.cnt));
      check({tag, "_busy"}, 32'(bus.busy), 32'd0);
      sweep(tag, e.frame);
    end
  endtask

  initial begin
    logic [FW-1:0] f;
    int p;

    bus.serial_in = 1'b0;
    bus.start_in = 1'b0;
    bus.rd_addr = '0;
    bus.err_clr = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    sweep("rst", '0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_cnt", 32'(bus.frame_cnt), 32'd0);
    check("rst_err", 32'(bus.err_restart), 32'd0);
    check("rst_done", 32'(bus.frame_done), 32'd0);
`ifdef REGFILE_SERIAL_RX_CHG_EN
    check("rst_chg", 32'(bus.chg_mask), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // Full frame of i*0x11
    for (int i = 0; i < NR; i++) f[i*RW +: RW] = 8'(i * 8'h11);
    p = pulses;
    start_pulse();
    #1 check("t2_busy_pre", 32'(bus.busy), 32'd0);
    send_bits(f, 0, 0);
    #1 check("t2_busy_t1", 32'(bus.busy), 32'd1);
    send_bits(f, 1, FW - 1);
    #1 check("t2_busy_last", 32'(bus.busy), 32'd1);
    push(f);
    wait_commit("t2");
    bus.rd_addr = 4'd5;
    #1 check("t2_a5", 32'(bus.rd_data), 32'h55);
    bus.rd_addr = 4'd15;
    #1 check("t2_a15", 32'(bus.rd_data), 32'hFF);
    repeat (3) @(negedge clk);
    #1 check("t2_pulses", 32'(pulses - p), 32'd1);

    // Restart mid-frame
    send_frame(fill(8'hA5), 1'b1);
    wait_commit("t3a");
    p = pulses;
    f = fill(8'h3C);
    start_pulse();
    send_bits(f, 0, 39);
    start_pulse();
    send_bits(f, 0, 99);
    #1;
    check("t3_err", 32'(bus.err_restart), 32'd1);
    check("t3_nodone", 32'(pulses - p), 32'd0);
    bus.rd_addr = 4'd0;
    #1 check("t3_hold", 32'(bus.rd_data), 32'hA5);
    send_bits(f, 100, FW - 1);
    push(f);
    wait_commit("t3b");
    @(negedge clk);
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    #1 check("t3_clr", 32'(bus.err_restart), 32'd0);

    // Start on the last-bit edge, err_clr on the same edge
    p = pulses;
    start_pulse();
    send_bits(fill(8'h77), 0, FW - 2);
    @(negedge clk);
    bus.start_in = 1'b1;
    bus.err_clr = 1'b1;
    bus.serial_in = 1'b1;
    f = fill(8'h5A);
    send_bits(f, 0, FW - 1);
    #1;
    check("t4_err", 32'(bus.err_restart), 32'd1);
    check("t4_nodone", 32'(pulses - p), 32'd0);
    bus.rd_addr = 4'd9;
    #1 check("t4_hold", 32'(bus.rd_data), 32'h3C);
    push(f);
    wait_commit("t4");

    // Reset at bit 70
    p = pulses;
    start_pulse();
    send_bits(fill(8'hC3), 0, 69);
    do_reset();
    repeat (140) @(negedge clk);
    #1;
    check("t6_nodone", 32'(pulses - p), 32'd0);
    check("t6_cnt", 32'(bus.frame_cnt), 32'd0);
    check("t6_busy", 32'(bus.busy), 32'd0);
    sweep("t6", '0);

`ifdef REGFILE_SERIAL_RX_CHG_EN
    f = '0;
    f[3*RW +: RW] = 8'h01;
    send_frame(f, 1'b1);
    wait_commit("chg1");
    check("chg_first", 32'(bus.chg_mask), 32'h0008);
    send_frame(f, 1'b1);
    wait_commit("chg2");
    check("chg_same", 32'(bus.chg_mask), 32'h0000);
    do_reset();
`endif

    // 257 back-to-back frames
    p = pulses;
    for (int n = 0; n < 257; n++) send_frame(fill(8'(n)), 1'b0);
    repeat (2) @(negedge clk);
    #1;
    check("t5_pulses", 32'(pulses - p), 32'd257);
    check("t5_cnt", 32'(bus.frame_cnt), 32'd1);
    bus.rd_addr = 4'd7;
    #1 check("t5_last", 32'(bus.rd_data), 32'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
